// File: rtl/orv64_clk_gate_ctrl.sv
// Enable-side controller for the orv64 clock-gating cell: idle hysteresis, drain
// window, wake handshake with settle delay, and a saturating gated-cycle counter.
module orv64_clk_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES  = 16,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES  = 2,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_gate_en,
  input  logic              scan_mode,
  input  logic              busy,
  input  logic              wake_req,
  output logic              wake_ack,
  output logic              en,
  output logic              tst_en,
  output logic              gated,
  output logic [PERF_W-1:0] gated_cycles,
  input  logic              perf_clr
);

  localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  if (IDLE_CYCLES < 1 || IDLE_CYCLES > CNT_MAX ||
      DRAIN_CYCLES < 1 || DRAIN_CYCLES > CNT_MAX ||
      WAKE_CYCLES < 1 || WAKE_CYCLES > CNT_MAX) begin : g_param_chk
    $error("orv64_clk_gate_ctrl: cycle parameter outside 1..2^CNT_W-1");
  end

  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                en_q, en_d;
  logic [PERF_W-1:0]   gated_cycles_q, gated_cycles_d;

  logic idle_c;
  logic wake_c;

  assign idle_c = !busy && !wake_req && cfg_gate_en && !scan_mode;
  assign wake_c = busy || wake_req || !cfg_gate_en || scan_mode;

  // Next-state and shared counter; wake wins over idle/drain completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ON: begin
        if (!idle_c) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(IDLE_CYCLES - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (wake_c) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OFF: begin
        if (wake_c) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        // Wake always completes, even if the requester withdraws.
        if (cnt_q == CNT_W'(WAKE_CYCLES - 1)) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_ON;
        cnt_d   = '0;
      end
    endcase
  end

  // Enable follows next state so it switches with the state register.
  always_comb begin
    en_d           = (state_d != ST_OFF);
    gated_cycles_d = gated_cycles_q;
    if (perf_clr) begin
      gated_cycles_d = '0;
    end else if (state_q == ST_OFF && gated_cycles_q != {PERF_W{1'b1}}) begin
      gated_cycles_d = gated_cycles_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_ON;
      cnt_q          <= '0;
      en_q           <= 1'b1;
      gated_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      en_q           <= en_d;
      gated_cycles_q <= gated_cycles_d;
    end
  end

  assign en           = en_q;
  assign tst_en       = scan_mode;
  assign gated        = (state_q == ST_OFF);
  assign wake_ack     = (state_q == ST_ON) && wake_req;
  assign gated_cycles = gated_cycles_q;

endmodule

// File: tb/tb_orv64_clk_gate_ctrl.sv
// Directed bench for orv64_clk_gate_ctrl; a second instance with PERF_W=4
// shares all stimulus to exercise counter saturation.
module tb_orv64_clk_gate_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_gate_en;
  logic        scan_mode;
  logic        busy;
  logic        wake_req;
  logic        perf_clr;
  logic        wake_ack, en, tst_en, gated;
  logic [31:0] gated_cycles;
  logic        p_wake_ack, p_en, p_tst_en, p_gated;
  logic [3:0]  p_gated_cycles;

  int checks = 0;
  int errs   = 0;

  orv64_clk_gate_ctrl u_dut (
    .clk(clk), .rst(rst_n), .cfg_gate_en(cfg_gate_en), .scan_mode(scan_mode),
    .busy(busy), .wake_req(wake_req), .wake_ack(wake_ack), .en(en),
    .tst_en(tst_en), .gated(gated), .gated_cycles(gated_cycles), .perf_clr(perf_clr)
  );

  orv64_clk_gate_ctrl #(.PERF_W(4)) u_perf (
    .clk(clk), .rst(rst_n), .cfg_gate_en(cfg_gate_en), .scan_mode(scan_mode),
    .busy(busy), .wake_req(wake_req), .wake_ack(p_wake_ack), .en(p_en),
    .tst_en(p_tst_en), .gated(p_gated), .gated_cycles(p_gated_cycles), .perf_clr(perf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cfg_gate_en = 1'b1; scan_mode = 1'b0;
    busy = 1'b0; wake_req = 1'b0; perf_clr = 1'b0;
    tick(3);
    checks++; if (en !== 1'b1) begin errs++; $display("FAIL reset_en: got %b expected 1", en); end
    checks++; if (gated !== 1'b0) begin errs++; $display("FAIL reset_gated: got %b expected 0", gated); end
    checks++; if (wake_ack !== 1'b0) begin errs++; $display("FAIL reset_ack: got %b expected 0", wake_ack); end
    checks++; if (gated_cycles !== 32'd0) begin errs++; $display("FAIL reset_cycles: got %0d expected 0", gated_cycles); end
    checks++; if (tst_en !== 1'b0) begin errs++; $display("FAIL reset_tst_en: got %b expected 0", tst_en); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_hysteresis;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      checks++;
      if (en !== (i < 20)) begin errs++; $display("FAIL idle_en[%0d]: got %b expected %b", i, en, (i < 20)); end
    end
    checks++; if (gated !== 1'b1) begin errs++; $display("FAIL idle_gated: got %b expected 1", gated); end
    checks++; if (gated_cycles !== 32'd0) begin errs++; $display("FAIL idle_cycles0: got %0d expected 0", gated_cycles); end
    tick(5);
    checks++; if (gated_cycles !== 32'd5) begin errs++; $display("FAIL idle_cycles5: got %0d expected 5", gated_cycles); end
  endtask

  task automatic test_wake_from_off;
    wake_req = 1'b1;
    #1;
    checks++; if (wake_ack !== 1'b0 || en !== 1'b0) begin errs++; $display("FAIL wake_t0: got ack=%b en=%b expected ack=0 en=0", wake_ack, en); end
    tick(1);
    checks++; if (en !== 1'b1 || gated !== 1'b0 || wake_ack !== 1'b0) begin errs++; $display("FAIL wake_t1: got en=%b gated=%b ack=%b expected 1 0 0", en, gated, wake_ack); end
    checks++; if (gated_cycles !== 32'd6) begin errs++; $display("FAIL wake_cycles: got %0d expected 6", gated_cycles); end
    tick(1);
    checks++; if (wake_ack !== 1'b0) begin errs++; $display("FAIL wake_t2_ack: got %b expected 0", wake_ack); end
    tick(1);
    checks++; if (wake_ack !== 1'b1 || en !== 1'b1) begin errs++; $display("FAIL wake_t3: got ack=%b en=%b expected 1 1", wake_ack, en); end
    wake_req = 1'b0;
    #1;
    checks++; if (wake_ack !== 1'b0) begin errs++; $display("FAIL wake_release_ack: got %b expected 0", wake_ack); end
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      checks++;
      if (en !== (i < 20)) begin errs++; $display("FAIL wake_regate_en[%0d]: got %b expected %b", i, en, (i < 20)); end
    end
  endtask

  task automatic test_abort_drain;
    busy = 1'b1;
    tick(4);
    checks++; if (en !== 1'b1 || gated !== 1'b0) begin errs++; $display("FAIL abort_wake: got en=%b gated=%b expected 1 0", en, gated); end
    busy = 1'b0;
    tick(17);
    checks++; if (en !== 1'b1) begin errs++; $display("FAIL abort_drain2_en: got %b expected 1", en); end
    busy = 1'b1;
    tick(1);
    busy = 1'b0;
    checks++; if (en !== 1'b1 || gated !== 1'b0) begin errs++; $display("FAIL abort_hit: got en=%b gated=%b expected 1 0", en, gated); end
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      checks++;
      if (en !== (i < 20)) begin errs++; $display("FAIL abort_regate_en[%0d]: got %b expected %b", i, en, (i < 20)); end
    end
  endtask

  task automatic test_busy_glitch;
    busy = 1'b1;
    tick(4);
    busy = 1'b0;
    tick(14);
    busy = 1'b1;
    tick(1);
    busy = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      checks++;
      if (en !== (i < 20)) begin errs++; $display("FAIL glitch_en[%0d]: got %b expected %b", i, en, (i < 20)); end
    end
    checks++; if (gated !== 1'b1) begin errs++; $display("FAIL glitch_gated: got %b expected 1", gated); end
  endtask

  task automatic test_overrides;
    scan_mode = 1'b1;
    #1;
    checks++; if (tst_en !== 1'b1 || en !== 1'b0) begin errs++; $display("FAIL scan_t0: got tst_en=%b en=%b expected 1 0", tst_en, en); end
    tick(1);
    checks++; if (en !== 1'b1) begin errs++; $display("FAIL scan_t1_en: got %b expected 1", en); end
    for (int i = 0; i < 30; i++) begin
      tick(1);
      checks++;
      if (en !== 1'b1 || gated !== 1'b0) begin errs++; $display("FAIL scan_hold[%0d]: got en=%b gated=%b expected 1 0", i, en, gated); end
    end
    scan_mode = 1'b0;
    tick(20);
    checks++; if (en !== 1'b0 || tst_en !== 1'b0) begin errs++; $display("FAIL scan_regate: got en=%b tst_en=%b expected 0 0", en, tst_en); end
    cfg_gate_en = 1'b0;
    tick(1);
    checks++; if (en !== 1'b1) begin errs++; $display("FAIL cfg_t1_en: got %b expected 1", en); end
    for (int i = 0; i < 30; i++) begin
      tick(1);
      checks++;
      if (en !== 1'b1 || gated !== 1'b0) begin errs++; $display("FAIL cfg_hold[%0d]: got en=%b gated=%b expected 1 0", i, en, gated); end
    end
    cfg_gate_en = 1'b1;
    tick(19);
    checks++; if (en !== 1'b1) begin errs++; $display("FAIL cfg_regate19: got %b expected 1", en); end
    tick(1);
    checks++; if (en !== 1'b0) begin errs++; $display("FAIL cfg_regate20: got %b expected 0", en); end
  endtask

  task automatic test_perf_reset;
    perf_clr = 1'b1;
    tick(1);
    perf_clr = 1'b0;
    checks++; if (gated_cycles !== 32'd0 || p_gated_cycles !== 4'd0) begin errs++; $display("FAIL perf_clr0: got %0d/%0d expected 0/0", gated_cycles, p_gated_cycles); end
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      checks++;
      if (gated_cycles !== 32'(i) || p_gated_cycles !== 4'((i < 15) ? i : 15)) begin
        errs++;
        $display("FAIL perf_count[%0d]: got %0d/%0d expected %0d/%0d", i, gated_cycles, p_gated_cycles, i, (i < 15) ? i : 15);
      end
    end
    perf_clr = 1'b1;
    tick(1);
    perf_clr = 1'b0;
    checks++; if (gated_cycles !== 32'd0 || p_gated_cycles !== 4'd0) begin errs++; $display("FAIL perf_clr_wins: got %0d/%0d expected 0/0", gated_cycles, p_gated_cycles); end
    tick(2);
    checks++; if (gated_cycles !== 32'd2 || en !== 1'b0) begin errs++; $display("FAIL perf_pre_rst: got cycles=%0d en=%b expected 2 0", gated_cycles, en); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (en !== 1'b1 || gated !== 1'b0 || wake_ack !== 1'b0) begin errs++; $display("FAIL async_rst: got en=%b gated=%b ack=%b expected 1 0 0", en, gated, wake_ack); end
    checks++; if (gated_cycles !== 32'd0 || p_gated_cycles !== 4'd0) begin errs++; $display("FAIL async_rst_cycles: got %0d/%0d expected 0/0", gated_cycles, p_gated_cycles); end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    checks++; if (en !== 1'b1 || gated !== 1'b0) begin errs++; $display("FAIL post_rst: got en=%b gated=%b expected 1 0", en, gated); end
  endtask

  initial begin
    test_reset();
    test_idle_hysteresis();
    test_wake_from_off();
    test_abort_drain();
    test_busy_glitch();
    test_overrides();
    test_perf_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
